// File: rtl/wb_pkg.sv
// Shared Wishbone slave definitions: FSM state encoding, bus width defaults
// and a constant-evaluable ceil(log2) helper.
package wb_pkg;

   localparam int WB_DWIDTH_DEF = 32;
   localparam int WB_AWIDTH_DEF = 32;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

endpackage

// File: rtl/wb_slave_mem_array.sv
// DEPTH x DWIDTH synchronous RAM with per-byte write enables and a registered,
// enable-gated read port that holds its value between reads.
module wb_slave_mem_array
   import wb_pkg::*;
#(
   parameter int DWIDTH = WB_DWIDTH_DEF,
   parameter int DEPTH  = 1024,
   parameter int RAW    = (DEPTH > 1) ? clog2(DEPTH) : 1
) (
   input  logic                i_ck,
   input  logic                i_rst,
   input  logic                i_we,
   input  logic [DWIDTH/8-1:0] i_be,
   input  logic                i_re,
   input  logic [RAW-1:0]      i_addr,
   input  logic [DWIDTH-1:0]   i_wdat,
   output logic [DWIDTH-1:0]   o_rdat
);

   localparam int NB = DWIDTH / 8;

   logic [DWIDTH-1:0] mem_q [DEPTH];
   logic [DWIDTH-1:0] rdat_q;

   always_ff @(posedge i_ck) begin
      if (i_we) begin
         for (int b = 0; b < NB; b++) begin
            if (i_be[b]) mem_q[i_addr][b*8 +: 8] <= i_wdat[b*8 +: 8];
         end
      end
   end

   // Only the read-data register is reset; the array contents survive reset.
   always_ff @(posedge i_ck) begin
      if (i_rst)     rdat_q <= '0;
      else if (i_re) rdat_q <= mem_q[i_addr];
   end

   assign o_rdat = rdat_q;

endmodule

// File: rtl/wb_slave_mem.sv
// Wishbone slave memory: IDLE/WAIT/RESP handshake FSM with programmable wait
// states, word-index range check and registered ack/err terminations.
module wb_slave_mem
   import wb_pkg::*;
#(
   parameter int DWIDTH      = WB_DWIDTH_DEF,
   parameter int AWIDTH      = WB_AWIDTH_DEF,
   parameter int DEPTH       = 1024,
   parameter int WAIT_STATES = 1
) (
   input  logic                i_ck,
   input  logic                i_rst,
   input  logic                i_wb_cyc,
   input  logic                i_wb_stb,
   input  logic                i_wb_we,
   input  logic [DWIDTH/8-1:0] i_wb_sel,
   input  logic [AWIDTH-1:0]   i_wb_adr,
   input  logic [DWIDTH-1:0]   i_wb_dat,
   output logic [DWIDTH-1:0]   o_wb_dat,
   output logic                o_wb_ack,
   output logic                o_wb_err
);

   localparam int              BSHIFT  = clog2(DWIDTH / 8);
   localparam int              RAW     = (DEPTH > 1) ? clog2(DEPTH) : 1;
   localparam logic [AWIDTH-1:0] DEPTH_A = AWIDTH'(DEPTH);
   localparam logic [3:0]      WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   logic [1:0]        state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              ack_q, ack_d;
   logic              err_q, err_d;
   logic              req, access, in_range;
   logic [AWIDTH-1:0] word_idx;

   assign req      = i_wb_cyc & i_wb_stb;
   assign word_idx = i_wb_adr >> BSHIFT;
   assign in_range = (word_idx < DEPTH_A);

   // 'access' marks the edge that enters RESP: memory is touched only there.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      access  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (req) begin
               if (WAIT_STATES == 0) begin
                  state_d = ST_RESP;
                  access  = 1'b1;
               end else begin
                  state_d = ST_WAIT;
                  cnt_d   = WS_LOAD;
               end
            end
         end
         ST_WAIT: begin
            if (!req) begin
               state_d = ST_IDLE;
            end else if (cnt_q == 4'd0) begin
               state_d = ST_RESP;
               access  = 1'b1;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (i_rst) begin
         state_d = ST_IDLE;
         cnt_d   = 4'd0;
         access  = 1'b0;
      end
   end

   assign ack_d = access & in_range;
   assign err_d = access & ~in_range;

   always_ff @(posedge i_ck) begin
      if (i_rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= 4'd0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
      end
   end

   wb_slave_mem_array #(
      .DWIDTH (DWIDTH),
      .DEPTH  (DEPTH),
      .RAW    (RAW)
   ) u_array (
      .i_ck   (i_ck),
      .i_rst  (i_rst),
      .i_we   (access & in_range & i_wb_we),
      .i_be   (i_wb_sel),
      .i_re   (access & in_range & ~i_wb_we),
      .i_addr (word_idx[RAW-1:0]),
      .i_wdat (i_wb_dat),
      .o_rdat (o_wb_dat)
   );

   assign o_wb_ack = ack_q;
   assign o_wb_err = err_q;

endmodule

// File: tb/tb_wb_slave_mem.sv
// Bench for wb_slave_mem: three instances (WS=1/DEPTH=1000, WS=3, WS=0) on a
// shared bus whose cyc is steered to one target at a time.
module tb_wb_slave_mem;

   typedef struct {
      logic        we;
      logic [31:0] adr;
      logic [3:0]  sel;
      logic [31:0] wdat;
      logic        exp_err;
      logic [31:0] exp_dat;
   } vec_t;

   typedef struct {
      logic        exp_err;
      logic [31:0] exp_dat;
   } sb_t;

   logic        i_ck = 1'b0;
   logic        rst, cyc, stb, we;
   logic [3:0]  sel;
   logic [31:0] adr, wdat;
   int          tgt;
   logic [2:0]  ack, err;
   logic [31:0] dat [3];

   int   checks = 0;
   int   errors = 0;
   sb_t  sbq[$];
   vec_t vecs[17];

   always #5 i_ck = ~i_ck;

   wb_slave_mem #(.DWIDTH(32), .AWIDTH(32), .DEPTH(1000), .WAIT_STATES(1)) u0 (
      .i_ck(i_ck), .i_rst(rst), .i_wb_cyc(cyc && (tgt == 0)), .i_wb_stb(stb),
      .i_wb_we(we), .i_wb_sel(sel), .i_wb_adr(adr), .i_wb_dat(wdat),
      .o_wb_dat(dat[0]), .o_wb_ack(ack[0]), .o_wb_err(err[0]));

   wb_slave_mem #(.DWIDTH(32), .AWIDTH(32), .DEPTH(1024), .WAIT_STATES(3)) u1 (
      .i_ck(i_ck), .i_rst(rst), .i_wb_cyc(cyc && (tgt == 1)), .i_wb_stb(stb),
      .i_wb_we(we), .i_wb_sel(sel), .i_wb_adr(adr), .i_wb_dat(wdat),
      .o_wb_dat(dat[1]), .o_wb_ack(ack[1]), .o_wb_err(err[1]));

   wb_slave_mem #(.DWIDTH(32), .AWIDTH(32), .DEPTH(1024), .WAIT_STATES(0)) u2 (
      .i_ck(i_ck), .i_rst(rst), .i_wb_cyc(cyc && (tgt == 2)), .i_wb_stb(stb),
      .i_wb_we(we), .i_wb_sel(sel), .i_wb_adr(adr), .i_wb_dat(wdat),
      .o_wb_dat(dat[2]), .o_wb_ack(ack[2]), .o_wb_err(err[2]));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Ack/err must never overlap, and untargeted instances must stay silent.
   always @(negedge i_ck) begin
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("ack_err_excl[%0d]", i), {31'd0, ack[i] & err[i]}, 32'd0);
         chk($sformatf("idle_quiet[%0d]", i), {31'd0, (ack[i] | err[i]) && (i != tgt)}, 32'd0);
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: time %0t exceeded limit 500000", $time);
      $fatal(1, "watchdog");
   end

   // One transfer; optionally re-drive adr/wdat after chg_at cycles in WAIT.
   task automatic xfer(input int t, input logic w, input logic [31:0] a, input logic [3:0] s,
                       input logic [31:0] d, input logic e_err, input logic [31:0] e_dat,
                       input int lat, input int chg_at, input logic [31:0] a2,
                       input logic [31:0] d2);
      int   n;
      logic done;
      sb_t  e;
      sbq.push_back('{e_err, e_dat});
      tgt = t; cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; wdat = d;
      n = 0; done = 1'b0;
      while (!done && n < 24) begin
         @(negedge i_ck);
         n++;
         if (ack[t] | err[t]) done = 1'b1;
         else if (n == chg_at) begin adr = a2; wdat = d2; end
      end
      cyc = 1'b0; stb = 1'b0;
      chk("termination_seen", {31'd0, done}, 32'd1);
      chk("latency", n, lat);
      e = sbq.pop_front();
      chk("err", {31'd0, err[t]}, {31'd0, e.exp_err});
      chk("ack", {31'd0, ack[t]}, {31'd0, ~e.exp_err});
      chk("rdata", dat[t], e.exp_dat);
      @(negedge i_ck);
      chk("single_pulse", {31'd0, ack[t] | err[t]}, 32'd0);
   endtask

   initial begin
      int acks;
      logic prev;

      vecs[0]  = '{1'b1, 32'h0000_0010, 4'hF, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000};
      vecs[1]  = '{1'b0, 32'h0000_0010, 4'hF, 32'h0000_0000, 1'b0, 32'hDEAD_BEEF};
      vecs[2]  = '{1'b1, 32'h0000_0020, 4'hF, 32'h1122_3344, 1'b0, 32'hDEAD_BEEF};
      vecs[3]  = '{1'b1, 32'h0000_0020, 4'h5, 32'hAABB_CCDD, 1'b0, 32'hDEAD_BEEF};
      vecs[4]  = '{1'b0, 32'h0000_0020, 4'h0, 32'h0000_0000, 1'b0, 32'h11BB_33DD};
      vecs[5]  = '{1'b1, 32'h0000_0F9C, 4'hF, 32'h9999_0999, 1'b0, 32'h11BB_33DD};
      vecs[6]  = '{1'b0, 32'h0000_0FA0, 4'hF, 32'h0000_0000, 1'b1, 32'h11BB_33DD};
      vecs[7]  = '{1'b1, 32'h0000_0FA0, 4'hF, 32'h1234_5678, 1'b1, 32'h11BB_33DD};
      vecs[8]  = '{1'b0, 32'h0000_0F9C, 4'hF, 32'h0000_0000, 1'b0, 32'h9999_0999};
      vecs[9]  = '{1'b0, 32'h0000_0013, 4'hF, 32'h0000_0000, 1'b0, 32'hDEAD_BEEF};
      vecs[10] = '{1'b1, 32'h0000_0010, 4'h0, 32'hFFFF_FFFF, 1'b0, 32'hDEAD_BEEF};
      vecs[11] = '{1'b0, 32'h0000_0010, 4'hF, 32'h0000_0000, 1'b0, 32'hDEAD_BEEF};
      vecs[12] = '{1'b1, 32'h0000_0014, 4'hF, 32'h0000_0000, 1'b0, 32'hDEAD_BEEF};
      vecs[13] = '{1'b1, 32'h0000_0014, 4'hA, 32'hCAFE_F00D, 1'b0, 32'hDEAD_BEEF};
      vecs[14] = '{1'b0, 32'h0000_0014, 4'hF, 32'h0000_0000, 1'b0, 32'hCA00_F000};
      vecs[15] = '{1'b0, 32'hFFFF_FFFC, 4'hF, 32'h0000_0000, 1'b1, 32'hCA00_F000};
      vecs[16] = '{1'b0, 32'h0000_0F9F, 4'hF, 32'h0000_0000, 1'b0, 32'h9999_0999};

      // Reset with a request pending: the request must be ignored.
      rst = 1'b1; tgt = 2; cyc = 1'b1; stb = 1'b1; we = 1'b1;
      adr = 32'h10; sel = 4'hF; wdat = 32'hFFFF_FFFF;
      repeat (3) @(negedge i_ck);
      for (int i = 0; i < 3; i++) begin
         chk("reset_ack", {31'd0, ack[i]}, 32'd0);
         chk("reset_err", {31'd0, err[i]}, 32'd0);
         chk("reset_dat", dat[i], 32'd0);
      end
      rst = 1'b0; cyc = 1'b0; stb = 1'b0;
      repeat (3) begin
         @(negedge i_ck);
         chk("req_during_reset", {31'd0, ack[2] | err[2]}, 32'd0);
      end

      for (int i = 0; i < 17; i++)
         xfer(0, vecs[i].we, vecs[i].adr, vecs[i].sel, vecs[i].wdat,
              vecs[i].exp_err, vecs[i].exp_dat, 2, -1, 32'd0, 32'd0);

      // Zero wait states, strobe held for 6 cycles: acks on alternate cycles.
      xfer(2, 1'b1, 32'h8, 4'hF, 32'h5A5A_1234, 1'b0, 32'd0, 1, -1, 32'd0, 32'd0);
      tgt = 2; cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h8; sel = 4'hF;
      acks = 0; prev = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge i_ck);
         if (ack[2]) begin
            acks++;
            chk("burst_rdata", dat[2], 32'h5A5A_1234);
         end
         chk("burst_no_b2b", {31'd0, prev & ack[2]}, 32'd0);
         prev = ack[2];
      end
      cyc = 1'b0; stb = 1'b0;
      chk("burst_ack_count", acks, 3);
      @(negedge i_ck);

      // Three wait states: preload, then abort a write by dropping stb.
      xfer(1, 1'b1, 32'h40, 4'hF, 32'h0102_0304, 1'b0, 32'd0, 4, -1, 32'd0, 32'd0);
      xfer(1, 1'b1, 32'h44, 4'hF, 32'h5566_7788, 1'b0, 32'd0, 4, -1, 32'd0, 32'd0);
      tgt = 1; cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h40; sel = 4'hF;
      wdat = 32'hFFFF_FFFF;
      repeat (2) @(negedge i_ck);
      stb = 1'b0;
      repeat (6) begin
         @(negedge i_ck);
         chk("abort_quiet", {31'd0, ack[1] | err[1]}, 32'd0);
      end
      cyc = 1'b0;
      xfer(1, 1'b0, 32'h40, 4'hF, 32'd0, 1'b0, 32'h0102_0304, 4, -1, 32'd0, 32'd0);

      // Address/data changed while waiting: RESP-entry values win.
      xfer(1, 1'b1, 32'h44, 4'hF, 32'h0BAD_F00D, 1'b0, 32'h0102_0304, 4, 1,
           32'h48, 32'h1357_9BDF);
      xfer(1, 1'b0, 32'h44, 4'hF, 32'd0, 1'b0, 32'h5566_7788, 4, -1, 32'd0, 32'd0);
      xfer(1, 1'b0, 32'h48, 4'hF, 32'd0, 1'b0, 32'h1357_9BDF, 4, -1, 32'd0, 32'd0);

      // Reset while a write is waiting.
      tgt = 1; cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h40; sel = 4'hF;
      wdat = 32'hBAD0_BAD0;
      @(negedge i_ck);
      rst = 1'b1;
      @(negedge i_ck);
      chk("rst_wait_ack", {31'd0, ack[1]}, 32'd0);
      chk("rst_wait_err", {31'd0, err[1]}, 32'd0);
      chk("rst_wait_dat", dat[1], 32'd0);
      rst = 1'b0; cyc = 1'b0; stb = 1'b0;
      repeat (5) begin
         @(negedge i_ck);
         chk("rst_wait_quiet", {31'd0, ack[1] | err[1]}, 32'd0);
      end
      xfer(1, 1'b0, 32'h40, 4'hF, 32'd0, 1'b0, 32'h0102_0304, 4, -1, 32'd0, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
